// File: rtl/nrzi_tx_serializer.sv
// nrzi_tx_serializer
//   Serializes bytes LSB first onto a registered NRZI line: a serial 1
//   toggles the line, a serial 0 holds it. Bytes are accepted with a
//   valid/ready handshake; a byte offered in the last bit slot of the
//   current byte follows it with no idle gap.
//
//   Optional feature (define NRZI_TX_BIT_STUFF_EN): after STUFF_LEN
//   consecutive transmitted 0 bits a 1 is inserted on the line. The
//   zero run carries across back-to-back bytes.
//
// Parameters
//   STUFF_LEN  consecutive zeros that force a stuffed 1 (1..15)
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high reset
//   tx_data   in   [7:0] byte to send, LSB first
//   tx_valid  in   tx_data valid
//   tx_ready  out  byte accepted this cycle if tx_valid is also high
//   nrzi_out  out  registered NRZI line
//   busy      out  high whenever a byte is being serialized
module nrzi_tx_serializer #(
  parameter int unsigned STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       nrzi_out,
  output logic       busy
);

  if (STUFF_LEN < 1 || STUFF_LEN > 15) begin : g_bad_stuff_len
    $error("nrzi_tx_serializer: STUFF_LEN must be in 1..15");
  end

`ifdef NRZI_TX_BIT_STUFF_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } state_t;

  localparam logic [3:0] STUFF_LEN_W = 4'(STUFF_LEN);
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       nrzi_nxt;
  logic       ready_int;
  logic       cur_bit;

`ifdef NRZI_TX_BIT_STUFF_EN
  logic [3:0] zero_cnt, zero_nxt, zero_inc;
  logic       stuff_hit;
  // Set when the pending STUFF slot follows bit 7; bit_cnt has already
  // wrapped at that point, so it cannot tell a final STUFF from a
  // mid-byte one on its own.
  logic       stuff_final, stuff_final_nxt;
`endif

  assign busy     = (state != IDLE);
  assign tx_ready = ready_int & ~reset;
  assign cur_bit  = shift_reg[0];

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    nrzi_nxt    = nrzi_out;
    ready_int   = 1'b0;
`ifdef NRZI_TX_BIT_STUFF_EN
    zero_nxt        = zero_cnt;
    zero_inc        = zero_cnt + 4'd1;
    stuff_hit       = 1'b0;
    stuff_final_nxt = stuff_final;
`endif

    unique case (state)
      IDLE: begin
        ready_int = 1'b1;
      end

      SHIFT: begin
        nrzi_nxt    = nrzi_out ^ cur_bit;
        shift_nxt   = {1'b0, shift_reg[7:1]};
        bit_cnt_nxt = bit_cnt + 3'd1;
`ifdef NRZI_TX_BIT_STUFF_EN
        zero_nxt  = cur_bit ? '0 : zero_inc;
        stuff_hit = ~cur_bit && (zero_inc == STUFF_LEN_W);
        if (stuff_hit) begin
          state_nxt       = STUFF;
          stuff_final_nxt = (bit_cnt == 3'd7);
        end else if (bit_cnt == 3'd7) begin
          ready_int = 1'b1;
        end
`else
        if (bit_cnt == 3'd7) begin
          ready_int = 1'b1;
        end
`endif
      end

`ifdef NRZI_TX_BIT_STUFF_EN
      STUFF: begin
        nrzi_nxt  = ~nrzi_out;
        zero_nxt  = '0;
        state_nxt = SHIFT;
        if (stuff_final) begin
          ready_int = 1'b1;
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Shared handshake for IDLE and the final slot of a byte: a transfer
    // (re)loads the shifter, otherwise a final slot falls back to IDLE.
    if (ready_int) begin
      if (tx_valid) begin
        shift_nxt   = tx_data;
        bit_cnt_nxt = '0;
        state_nxt   = SHIFT;
      end else if (state != IDLE) begin
        state_nxt = IDLE;
`ifdef NRZI_TX_BIT_STUFF_EN
        zero_nxt  = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      nrzi_out  <= 1'b0;
`ifdef NRZI_TX_BIT_STUFF_EN
      zero_cnt    <= '0;
      stuff_final <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      nrzi_out  <= nrzi_nxt;
`ifdef NRZI_TX_BIT_STUFF_EN
      zero_cnt    <= zero_nxt;
      stuff_final <= stuff_final_nxt;
`endif
    end
  end

endmodule
